// File: rtl/game_event_arbiter.sv
// Per-frame event arbiter: latches collision requests during a frame, commits at most one
// at startOfFrame, and owns the lives/score/fruits counters plus the game countdown timer.
module game_event_arbiter #(
    parameter int FRAMES_PER_SEC = 30,
    parameter int GAME_SECONDS   = 90,
    parameter int INVULN_FRAMES  = 30,
    parameter int FRUIT_SCORE    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       game_on,
    input  logic       hit_monster,
    input  logic       hit_missile,
    input  logic       fruit_eaten,
    output logic [1:0] livesCounter,
    output logic [3:0] scoreCounter,
    output logic [3:0] fruitsCounter,
    output logic [6:0] secondsLeft,
    output logic       timer_end,
    output logic       SingleHitPulse
);

    localparam logic [4:0] FRAME_LAST   = 5'(FRAMES_PER_SEC - 1);
    localparam logic [6:0] SECONDS_INIT = 7'(GAME_SECONDS);
    localparam logic [5:0] INVULN_LOAD  = 6'(INVULN_FRAMES);
    localparam logic [4:0] SCORE_STEP   = 5'(FRUIT_SCORE);
    localparam logic [3:0] FRUITS_MAX   = 4'd10;

    // Bit 0 = monster, bit 1 = missile, bit 2 = fruit.
    logic [2:0] req;
    logic [2:0] pending_reg, pending_next;

    logic [1:0] lives_reg, lives_next;
    logic [3:0] score_reg, score_next;
    logic [3:0] fruits_reg, fruits_next;
    logic [6:0] seconds_reg, seconds_next;
    logic       timer_end_reg, timer_end_next;
    logic       pulse_reg, pulse_next;
    logic [5:0] invuln_reg, invuln_next;
    logic [4:0] frame_reg, frame_next;

    logic       tick;
    logic       frozen;
    logic       vulnerable;
    logic [4:0] score_sum;

    assign req = {fruit_eaten, hit_missile, hit_monster};

    // A startOfFrame drops the old pending set and keeps only same-cycle requests,
    // which therefore belong to the next frame.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pending
            assign pending_next[gi] = game_on &
                (startOfFrame ? req[gi] : (pending_reg[gi] | req[gi]));
        end
    endgenerate

    assign tick       = startOfFrame & game_on;
    assign frozen     = (lives_reg == 2'd3) | timer_end_reg;
    assign vulnerable = (invuln_reg == 6'd0);
    assign score_sum  = {1'b0, score_reg} + SCORE_STEP;

    always_comb begin
        lives_next     = lives_reg;
        score_next     = score_reg;
        fruits_next    = fruits_reg;
        seconds_next   = seconds_reg;
        timer_end_next = timer_end_reg;
        pulse_next     = 1'b0;
        invuln_next    = invuln_reg;
        frame_next     = frame_reg;

        if (tick) begin
            if (!vulnerable) begin
                invuln_next = invuln_reg - 6'd1;
            end
            if (!frozen) begin
                if (pending_reg[0] && vulnerable) begin
                    lives_next  = 2'd3;
                    pulse_next  = 1'b1;
                    invuln_next = INVULN_LOAD;
                end else if (pending_reg[1] && vulnerable) begin
                    lives_next  = (lives_reg == 2'd3) ? 2'd3 : lives_reg + 2'd1;
                    pulse_next  = 1'b1;
                    invuln_next = INVULN_LOAD;
                end else if (pending_reg[2] && (fruits_reg != FRUITS_MAX)) begin
                    fruits_next = fruits_reg + 4'd1;
                    score_next  = (score_sum > 5'd15) ? 4'd15 : score_sum[3:0];
                end
            end
            // Countdown: one second every FRAMES_PER_SEC frames, stopping at zero.
            if (!timer_end_reg) begin
                if (frame_reg == FRAME_LAST) begin
                    frame_next = 5'd0;
                    if (seconds_reg != 7'd0) begin
                        seconds_next = seconds_reg - 7'd1;
                    end
                    if (seconds_reg == 7'd1) begin
                        timer_end_next = 1'b1;
                    end
                end else begin
                    frame_next = frame_reg + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg   <= 3'd0;
            lives_reg     <= 2'd0;
            score_reg     <= 4'd0;
            fruits_reg    <= 4'd0;
            seconds_reg   <= SECONDS_INIT;
            timer_end_reg <= 1'b0;
            pulse_reg     <= 1'b0;
            invuln_reg    <= 6'd0;
            frame_reg     <= 5'd0;
        end else begin
            pending_reg   <= pending_next;
            lives_reg     <= lives_next;
            score_reg     <= score_next;
            fruits_reg    <= fruits_next;
            seconds_reg   <= seconds_next;
            timer_end_reg <= timer_end_next;
            pulse_reg     <= pulse_next;
            invuln_reg    <= invuln_next;
            frame_reg     <= frame_next;
        end
    end

    assign livesCounter   = lives_reg;
    assign scoreCounter   = score_reg;
    assign fruitsCounter  = fruits_reg;
    assign secondsLeft    = seconds_reg;
    assign timer_end      = timer_end_reg;
    assign SingleHitPulse = pulse_reg;

endmodule

// File: tb/tb_game_event_arbiter.sv
// Directed self-checking bench for game_event_arbiter: fruit, hits, invulnerability,
// saturation, request boundary, hold/reset and the countdown timer.
module tb_game_event_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       game_on = 1'b0;
    logic       hit_monster = 1'b0;
    logic       hit_missile = 1'b0;
    logic       fruit_eaten = 1'b0;
    logic [1:0] lives;
    logic [3:0] score;
    logic [3:0] fruits;
    logic [6:0] secs;
    logic       tend;
    logic       pulse;

    int checks = 0;
    int fails  = 0;

    game_event_arbiter #(
        .FRAMES_PER_SEC(3),
        .GAME_SECONDS  (127),
        .INVULN_FRAMES (30),
        .FRUIT_SCORE   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .game_on       (game_on),
        .hit_monster   (hit_monster),
        .hit_missile   (hit_missile),
        .fruit_eaten   (fruit_eaten),
        .livesCounter  (lives),
        .scoreCounter  (score),
        .fruitsCounter (fruits),
        .secondsLeft   (secs),
        .timer_end     (tend),
        .SingleHitPulse(pulse)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    // One 3-cycle frame: request pulse mid-frame, idle cycle, then startOfFrame.
    task automatic frame(input logic m, input logic s, input logic f);
        hit_monster = m; hit_missile = s; fruit_eaten = f;
        tick();
        hit_monster = 1'b0; hit_missile = 1'b0; fruit_eaten = 1'b0;
        tick();
        sof();
        $display("frame m=%0b s=%0b f=%0b on=%0b -> lives=%0d score=%0d fruits=%0d secs=%0d end=%0b pulse=%0b",
                 m, s, f, game_on, lives, score, fruits, secs, tend, pulse);
    endtask

    task automatic do_reset();
        reset = 1'b1; game_on = 1'b0; startOfFrame = 1'b0;
        hit_monster = 1'b0; hit_missile = 1'b0; fruit_eaten = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        game_on = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        $display("test_reset: lives=%0d score=%0d fruits=%0d secs=%0d end=%0b pulse=%0b",
                 lives, score, fruits, secs, tend, pulse);
        checks++; if (lives !== 2'd0) begin fails++; $display("FAIL reset_lives: got %0d expected 0", lives); end
        checks++; if (score !== 4'd0) begin fails++; $display("FAIL reset_score: got %0d expected 0", score); end
        checks++; if (fruits !== 4'd0) begin fails++; $display("FAIL reset_fruits: got %0d expected 0", fruits); end
        checks++; if (secs !== 7'd127) begin fails++; $display("FAIL reset_secs: got %0d expected 127", secs); end
        checks++; if (tend !== 1'b0) begin fails++; $display("FAIL reset_timer_end: got %0b expected 0", tend); end
        checks++; if (pulse !== 1'b0) begin fails++; $display("FAIL reset_pulse: got %0b expected 0", pulse); end
        // Reset asserted together with startOfFrame and a pending monster must win.
        hit_monster = 1'b1;
        tick();
        hit_monster = 1'b0;
        reset = 1'b1; startOfFrame = 1'b1;
        tick();
        reset = 1'b0; startOfFrame = 1'b0;
        $display("test_reset_wins: lives=%0d pulse=%0b", lives, pulse);
        checks++; if (lives !== 2'd0) begin fails++; $display("FAIL reset_wins_lives: got %0d expected 0", lives); end
        checks++; if (pulse !== 1'b0) begin fails++; $display("FAIL reset_wins_pulse: got %0b expected 0", pulse); end
    endtask

    task automatic test_fruit_single();
        do_reset();
        frame(1'b0, 1'b0, 1'b1);
        checks++; if (fruits !== 4'd1) begin fails++; $display("FAIL fruit_single_fruits: got %0d expected 1", fruits); end
        checks++; if (score !== 4'd2) begin fails++; $display("FAIL fruit_single_score: got %0d expected 2", score); end
        checks++; if (pulse !== 1'b0) begin fails++; $display("FAIL fruit_single_pulse: got %0b expected 0", pulse); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        frame(1'b0, 1'b1, 1'b1);
        checks++; if (lives !== 2'd1) begin fails++; $display("FAIL simul_lives: got %0d expected 1", lives); end
        checks++; if (fruits !== 4'd0) begin fails++; $display("FAIL simul_fruits: got %0d expected 0", fruits); end
        checks++; if (pulse !== 1'b1) begin fails++; $display("FAIL simul_pulse_hi: got %0b expected 1", pulse); end
        tick();
        checks++; if (pulse !== 1'b0) begin fails++; $display("FAIL simul_pulse_lo: got %0b expected 0", pulse); end
        for (int k = 1; k <= 29; k++) begin
            if (k == 5) begin
                frame(1'b0, 1'b1, 1'b1);
                checks++; if (lives !== 2'd1) begin fails++; $display("FAIL invuln_lives: got %0d expected 1", lives); end
                checks++; if (fruits !== 4'd1) begin fails++; $display("FAIL invuln_fruit: got %0d expected 1", fruits); end
                checks++; if (pulse !== 1'b0) begin fails++; $display("FAIL invuln_pulse: got %0b expected 0", pulse); end
            end else begin
                frame(1'b0, 1'b0, 1'b0);
            end
        end
        frame(1'b0, 1'b1, 1'b0);
        checks++; if (lives !== 2'd1) begin fails++; $display("FAIL missile_f30_lives: got %0d expected 1", lives); end
        checks++; if (pulse !== 1'b0) begin fails++; $display("FAIL missile_f30_pulse: got %0b expected 0", pulse); end
        frame(1'b0, 1'b1, 1'b0);
        checks++; if (lives !== 2'd2) begin fails++; $display("FAIL missile_f31_lives: got %0d expected 2", lives); end
        checks++; if (pulse !== 1'b1) begin fails++; $display("FAIL missile_f31_pulse: got %0b expected 1", pulse); end
    endtask

    task automatic test_monster();
        do_reset();
        frame(1'b1, 1'b1, 1'b1);
        checks++; if (lives !== 2'd3) begin fails++; $display("FAIL monster_lives: got %0d expected 3", lives); end
        checks++; if (fruits !== 4'd0) begin fails++; $display("FAIL monster_fruits: got %0d expected 0", fruits); end
        checks++; if (pulse !== 1'b1) begin fails++; $display("FAIL monster_pulse_hi: got %0b expected 1", pulse); end
        tick();
        checks++; if (pulse !== 1'b0) begin fails++; $display("FAIL monster_pulse_lo: got %0b expected 0", pulse); end
        frame(1'b0, 1'b0, 1'b1);
        checks++; if (fruits !== 4'd0) begin fails++; $display("FAIL dead_fruit: got %0d expected 0", fruits); end
        checks++; if (score !== 4'd0) begin fails++; $display("FAIL dead_score: got %0d expected 0", score); end
        for (int k = 0; k < 31; k++) frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b1, 1'b0);
        checks++; if (lives !== 2'd3) begin fails++; $display("FAIL dead_lives: got %0d expected 3", lives); end
        checks++; if (pulse !== 1'b0) begin fails++; $display("FAIL dead_pulse: got %0b expected 0", pulse); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            frame(1'b0, 1'b0, 1'b1);
            if (i == 7) begin
                checks++; if (score !== 4'd14) begin fails++; $display("FAIL sat7_score: got %0d expected 14", score); end
            end
            if (i == 8) begin
                checks++; if (score !== 4'd15) begin fails++; $display("FAIL sat8_score: got %0d expected 15", score); end
                checks++; if (fruits !== 4'd8) begin fails++; $display("FAIL sat8_fruits: got %0d expected 8", fruits); end
            end
        end
        checks++; if (fruits !== 4'd10) begin fails++; $display("FAIL sat_fruits: got %0d expected 10", fruits); end
        checks++; if (score !== 4'd15) begin fails++; $display("FAIL sat_score: got %0d expected 15", score); end
    endtask

    task automatic test_boundary();
        do_reset();
        tick();
        fruit_eaten = 1'b1; startOfFrame = 1'b1;
        tick();
        fruit_eaten = 1'b0; startOfFrame = 1'b0;
        $display("test_boundary: after request sof fruits=%0d", fruits);
        checks++; if (fruits !== 4'd0) begin fails++; $display("FAIL boundary_now: got %0d expected 0", fruits); end
        tick();
        tick();
        sof();
        $display("test_boundary: after next sof fruits=%0d", fruits);
        checks++; if (fruits !== 4'd1) begin fails++; $display("FAIL boundary_next: got %0d expected 1", fruits); end
    endtask

    task automatic test_hold();
        do_reset();
        frame(1'b0, 1'b0, 1'b1);
        game_on = 1'b0;
        for (int k = 0; k < 3; k++) frame(1'b1, 1'b1, 1'b1);
        checks++; if (lives !== 2'd0) begin fails++; $display("FAIL hold_lives: got %0d expected 0", lives); end
        checks++; if (fruits !== 4'd1) begin fails++; $display("FAIL hold_fruits: got %0d expected 1", fruits); end
        checks++; if (secs !== 7'd127) begin fails++; $display("FAIL hold_secs: got %0d expected 127", secs); end
        checks++; if (pulse !== 1'b0) begin fails++; $display("FAIL hold_pulse: got %0b expected 0", pulse); end
        game_on = 1'b1;
        frame(1'b0, 1'b0, 1'b0);
        checks++; if (lives !== 2'd0) begin fails++; $display("FAIL hold_resume_lives: got %0d expected 0", lives); end
        checks++; if (secs !== 7'd127) begin fails++; $display("FAIL hold_resume_secs1: got %0d expected 127", secs); end
        frame(1'b0, 1'b0, 1'b0);
        checks++; if (secs !== 7'd126) begin fails++; $display("FAIL hold_resume_secs2: got %0d expected 126", secs); end
        // Mid-frame reset with a pending monster hit.
        hit_monster = 1'b1;
        tick();
        hit_monster = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("test_hold_reset: lives=%0d score=%0d fruits=%0d secs=%0d", lives, score, fruits, secs);
        checks++; if (fruits !== 4'd0) begin fails++; $display("FAIL midreset_fruits: got %0d expected 0", fruits); end
        checks++; if (score !== 4'd0) begin fails++; $display("FAIL midreset_score: got %0d expected 0", score); end
        checks++; if (secs !== 7'd127) begin fails++; $display("FAIL midreset_secs: got %0d expected 127", secs); end
        sof();
        checks++; if (pulse !== 1'b0) begin fails++; $display("FAIL midreset_pulse: got %0b expected 0", pulse); end
        checks++; if (lives !== 2'd0) begin fails++; $display("FAIL midreset_lives: got %0d expected 0", lives); end
    endtask

    task automatic test_timer();
        do_reset();
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        checks++; if (secs !== 7'd127) begin fails++; $display("FAIL timer_f2: got %0d expected 127", secs); end
        frame(1'b0, 1'b0, 1'b0);
        checks++; if (secs !== 7'd126) begin fails++; $display("FAIL timer_f3: got %0d expected 126", secs); end
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        checks++; if (secs !== 7'd125) begin fails++; $display("FAIL timer_f6: got %0d expected 125", secs); end
        for (int k = 7; k <= 380; k++) frame(1'b0, 1'b0, 1'b0);
        checks++; if (secs !== 7'd1) begin fails++; $display("FAIL timer_f380_secs: got %0d expected 1", secs); end
        checks++; if (tend !== 1'b0) begin fails++; $display("FAIL timer_f380_end: got %0b expected 0", tend); end
        frame(1'b0, 1'b0, 1'b0);
        checks++; if (secs !== 7'd0) begin fails++; $display("FAIL timer_f381_secs: got %0d expected 0", secs); end
        checks++; if (tend !== 1'b1) begin fails++; $display("FAIL timer_f381_end: got %0b expected 1", tend); end
        for (int k = 0; k < 4; k++) frame(1'b0, 1'b0, 1'b1);
        checks++; if (secs !== 7'd0) begin fails++; $display("FAIL timer_no_underflow: got %0d expected 0", secs); end
        checks++; if (tend !== 1'b1) begin fails++; $display("FAIL timer_sticky: got %0b expected 1", tend); end
        checks++; if (fruits !== 4'd0) begin fails++; $display("FAIL timer_frozen_fruit: got %0d expected 0", fruits); end
    endtask

    initial begin
        test_reset();
        test_fruit_single();
        test_simultaneous();
        test_monster();
        test_saturation();
        test_boundary();
        test_hold();
        test_timer();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
